// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259A host-side bus sequencer and its neighbours.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default bus timing, shared counter width and loader,
// ICW/OCW bit-field constants for command-word builders.
package pic_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_INTA1,
        ST_INTA_GAP,
        ST_INTA2,
        ST_INTA_END
    } pic_state_t;

    // Default bus timing, in core clock cycles (each legal range 1..15).
    localparam int unsigned DEF_SETUP_CYCLES    = 1;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;
    localparam int unsigned DEF_HOLD_CYCLES     = 1;
    localparam int unsigned DEF_INTA_GAP_CYCLES = 2;

    // One shared down-counter times every timed state.
    localparam int CNT_W = 4;

    // Command-word bit fields.
    localparam int          ICW1_INIT_BIT = 4;
    localparam int          OCW3_SEL_BIT  = 3;
    localparam logic [7:0]  ICW1_INIT     = 8'h10;
    localparam logic [7:0]  OCW3_SEL      = 8'h08;

    // Counter reload for a state lasting 'cycles' clocks; the state exits when
    // the counter reads zero, so the load value is cycles-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pic_host_bus_sequencer_if.sv
// Bundle of host command/response signals and 8259A-side pins.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake on the host command path.
//
// master: the sequencer view (drives bus strobes, cmd_ready, responses).
// slave : the host core plus PIC view (drives commands, data_in, interrupt).
interface pic_host_bus_sequencer_if;

    // host command / response
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       int_enable;
    logic       vector_valid;
    logic [7:0] vector;

    // PIC pins
    logic       chip_select_n;
    logic       read_n;
    logic       write_n;
    logic       ao_address_line;
    logic [7:0] data_out;
    logic       data_out_enable;
    logic [7:0] data_in;
    logic       interrupt;
    logic       interrupt_acknowledge_n;

    modport master (
        input  cmd_valid, cmd_write, cmd_a0, cmd_data, int_enable, data_in, interrupt,
        output cmd_ready, rsp_valid, rsp_data, vector_valid, vector,
               chip_select_n, read_n, write_n, ao_address_line,
               data_out, data_out_enable, interrupt_acknowledge_n
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_a0, cmd_data, int_enable, data_in, interrupt,
        input  cmd_ready, rsp_valid, rsp_data, vector_valid, vector,
               chip_select_n, read_n, write_n, ao_address_line,
               data_out, data_out_enable, interrupt_acknowledge_n
    );

endinterface

// File: rtl/pic_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk cycles.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out, resets to 0).
module pic_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pic_host_bus_sequencer.sv
// Host-side initiator for an 8259A: runs CS/RD/WR/A0 bus cycles and the two-pulse INTA handshake.
// Latency: command handshake to cmd_ready high again = SETUP+PULSE+HOLD+1 cycles; INTA = 2*PULSE+GAP+1.
// Backpressure: cmd_ready only in IDLE with no pending interrupt; an interrupt wins over a same-cycle command.
//
// Ports: clk, rst_n (async active-low); bus = pic_host_bus_sequencer_if.master carrying
// cmd_*/rsp_*/vector* toward the host core and CS_N/RD_N/WR_N/A0/data/INT/INTA_N toward the PIC.
module pic_host_bus_sequencer
    import pic_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned INTA_GAP_CYCLES = DEF_INTA_GAP_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pic_host_bus_sequencer_if.master bus
);

    pic_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    logic             int_sync;
    logic             int_req;
    logic             cmd_ready;
    logic             cmd_fire;

    // Registered outputs and latched command
    logic             cmd_write_q;
    logic             cs_n_q;
    logic             rd_n_q;
    logic             wr_n_q;
    logic             inta_n_q;
    logic             a0_q;
    logic [7:0]       data_out_q;
    logic             data_oe_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic             vector_valid_q;
    logic [7:0]       vector_q;

    pic_sync2 u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.interrupt),
        .q     (int_sync)
    );

    assign int_req   = int_sync & bus.int_enable;
    // rst_n gates ready so the host sees no acceptance while reset is held.
    assign cmd_ready = rst_n & (state == ST_IDLE) & ~int_req;
    assign cmd_fire  = bus.cmd_valid & cmd_ready;
    assign cnt_done  = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cmd_write_q    <= 1'b0;
            cs_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            inta_n_q       <= 1'b1;
            a0_q           <= 1'b0;
            data_out_q     <= 8'h00;
            data_oe_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= 8'h00;
            vector_valid_q <= 1'b0;
            vector_q       <= 8'h00;
        end else begin
            // Response and vector strobes are single-cycle pulses.
            rsp_valid_q    <= 1'b0;
            vector_valid_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (int_req) begin
                        state     <= ST_INTA1;
                        cnt       <= cnt_load(PULSE_CYCLES);
                        inta_n_q  <= 1'b0;
                        cs_n_q    <= 1'b1;
                        data_oe_q <= 1'b0;
                    end else if (cmd_fire) begin
                        state       <= ST_SETUP;
                        cnt         <= cnt_load(SETUP_CYCLES);
                        cmd_write_q <= bus.cmd_write;
                        a0_q        <= bus.cmd_a0;
                        data_out_q  <= bus.cmd_data;
                        cs_n_q      <= 1'b0;
                        data_oe_q   <= bus.cmd_write;
                    end
                end

                ST_SETUP: begin
                    if (cnt_done) begin
                        state  <= ST_STROBE;
                        cnt    <= cnt_load(PULSE_CYCLES);
                        wr_n_q <= ~cmd_write_q;
                        rd_n_q <= cmd_write_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (cnt_done) begin
                        state  <= ST_HOLD;
                        cnt    <= cnt_load(HOLD_CYCLES);
                        wr_n_q <= 1'b1;
                        rd_n_q <= 1'b1;
                        // Read data is taken at the end of the strobe, when the PIC
                        // has had the full pulse width to drive the bus.
                        if (!cmd_write_q) begin
                            rsp_data_q <= bus.data_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt_done) begin
                        state       <= ST_IDLE;
                        cs_n_q      <= 1'b1;
                        data_oe_q   <= 1'b0;
                        rsp_valid_q <= ~cmd_write_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // From here on the sequence runs to completion regardless of
                // INT or the enable; the PIC expects both pulses once started.
                ST_INTA1: begin
                    if (cnt_done) begin
                        state    <= ST_INTA_GAP;
                        cnt      <= cnt_load(INTA_GAP_CYCLES);
                        inta_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_INTA_GAP: begin
                    if (cnt_done) begin
                        state    <= ST_INTA2;
                        cnt      <= cnt_load(PULSE_CYCLES);
                        inta_n_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_INTA2: begin
                    if (cnt_done) begin
                        state          <= ST_INTA_END;
                        inta_n_q       <= 1'b1;
                        vector_q       <= bus.data_in;
                        vector_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_INTA_END: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready               = cmd_ready;
    assign bus.rsp_valid               = rsp_valid_q;
    assign bus.rsp_data                = rsp_data_q;
    assign bus.vector_valid            = vector_valid_q;
    assign bus.vector                  = vector_q;
    assign bus.chip_select_n           = cs_n_q;
    assign bus.read_n                  = rd_n_q;
    assign bus.write_n                 = wr_n_q;
    assign bus.ao_address_line         = a0_q;
    assign bus.data_out                = data_out_q;
    assign bus.data_out_enable         = data_oe_q;
    assign bus.interrupt_acknowledge_n = inta_n_q;

endmodule

// File: tb/tb_pic_host_bus_sequencer.sv
// Bench for pic_host_bus_sequencer: directed init/read/INTA/collision/mask/reset plus random ops.
// Expected transactions are queued by the driver; a negedge monitor rebuilds bus cycles and
// INTA sequences from the pins and compares them with the queue head.
module tb_pic_host_bus_sequencer;
    import pic_bus_pkg::*;

    localparam int S = DEF_SETUP_CYCLES;
    localparam int P = DEF_PULSE_CYCLES;
    localparam int H = DEF_HOLD_CYCLES;
    localparam int G = DEF_INTA_GAP_CYCLES;

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_INTA = 2;

    typedef struct {
        int         kind;
        logic       a0;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pic_host_bus_sequencer_if bus();

    pic_host_bus_sequencer #(
        .SETUP_CYCLES    (S),
        .PULSE_CYCLES    (P),
        .HOLD_CYCLES     (H),
        .INTA_GAP_CYCLES (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   n_rd_exp = 0, n_inta_exp = 0, n_rsp_seen = 0, n_vv_seen = 0;

    // ---------------- PIC data-bus model ----------------
    logic [7:0] pic_dout    = 8'hEE;
    logic [7:0] pic_status  = 8'h00;
    logic [7:0] pic_vector  = 8'h00;
    bit         inta_second = 1'b0;
    assign bus.data_in = pic_dout;

    // Status on RD; junk on the first INTA pulse, the vector on the second.
    always @(negedge bus.read_n or negedge bus.interrupt_acknowledge_n) begin
        if (!bus.read_n) begin
            pic_dout = pic_status;
        end else if (!bus.interrupt_acknowledge_n) begin
            pic_dout    = inta_second ? pic_vector : 8'hEE;
            inta_second = !inta_second;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit         in_cs = 0;
    int         cs_len, st_off, st_len, oe_cnt;
    bit         saw_rd, saw_wr, hold_ok;
    logic       cyc_a0;
    logic [7:0] cyc_data;
    int         ia_phase = 0;
    int         p1_len, gap_len, p2_len;

    task automatic finish_bus();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_bus_cycle_queue_len", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        chk("bus_kind", saw_wr ? K_WR : (saw_rd ? K_RD : 9), e.kind);
        chk("bus_both_strobes", saw_rd && saw_wr, 0);
        chk("bus_a0", cyc_a0, e.a0);
        chk("bus_a0_data_stable", hold_ok, 1);
        chk("cs_low_cycles", cs_len, S + P + H);
        chk("strobe_offset", st_off, S);
        chk("strobe_width", st_len, P);
        chk("data_oe_cycles", oe_cnt, (e.kind == K_WR) ? S + P + H : 0);
        chk("data_oe_after", bus.data_out_enable, 0);
        chk("rsp_valid_at_end", bus.rsp_valid, e.kind == K_RD);
        if (e.kind == K_WR) chk("write_data", cyc_data, e.data);
        else                chk("rsp_data", bus.rsp_data, e.data);
    endtask

    task automatic finish_inta();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_inta_queue_len", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        chk("inta_kind", K_INTA, e.kind);
        chk("inta1_width", p1_len, P);
        chk("inta_gap", gap_len, G);
        chk("inta2_width", p2_len, P);
        chk("vector_valid", bus.vector_valid, 1);
        chk("vector", bus.vector, e.data);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_cs    = 0;
            ia_phase = 0;
        end else begin
            chk("strobe_exclusive",
                (int'(!bus.read_n) + int'(!bus.write_n) + int'(!bus.interrupt_acknowledge_n)) <= 1, 1);
            if (!bus.interrupt_acknowledge_n) chk("cs_during_inta", bus.chip_select_n, 1);
            if (bus.rsp_valid)    n_rsp_seen++;
            if (bus.vector_valid) n_vv_seen++;

            if (!bus.chip_select_n) begin
                if (!in_cs) begin
                    in_cs    = 1;
                    cs_len   = 0;
                    st_off   = -1;
                    st_len   = 0;
                    oe_cnt   = 0;
                    saw_rd   = 0;
                    saw_wr   = 0;
                    hold_ok  = 1;
                    cyc_a0   = bus.ao_address_line;
                    cyc_data = bus.data_out;
                end
                if (!bus.read_n || !bus.write_n) begin
                    if (st_off < 0) st_off = cs_len;
                    st_len++;
                end
                if (!bus.read_n)  saw_rd = 1;
                if (!bus.write_n) saw_wr = 1;
                if (bus.data_out_enable) oe_cnt++;
                if (bus.ao_address_line !== cyc_a0 || bus.data_out !== cyc_data) hold_ok = 0;
                cs_len++;
            end else if (in_cs) begin
                in_cs = 0;
                finish_bus();
            end

            case (ia_phase)
                0: if (!bus.interrupt_acknowledge_n) begin ia_phase = 1; p1_len = 1; end
                1: if (!bus.interrupt_acknowledge_n) p1_len++;
                   else begin ia_phase = 2; gap_len = 1; end
                2: if (bus.interrupt_acknowledge_n) gap_len++;
                   else begin ia_phase = 3; p2_len = 1; end
                default: if (!bus.interrupt_acknowledge_n) p2_len++;
                   else begin ia_phase = 0; finish_inta(); end
            endcase
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_inta_low(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.interrupt_acknowledge_n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_vv(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.vector_valid) begin ok = 1; break; end
        end
    endtask

    task automatic do_cmd(input bit w, input bit a0, input logic [7:0] d,
                          input logic [7:0] status, output int waited);
        bit   got;
        int   lat;
        exp_t e;
        if (!w) pic_status = status;
        @(negedge clk);
        bus.cmd_write = w;
        bus.cmd_a0    = a0;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        waited = 0;
        got    = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready) begin got = 1; break; end
            waited++;
            @(negedge clk);
        end
        chk("cmd_accept_timeout", got, 1);
        if (!got) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        e.kind = w ? K_WR : K_RD;
        e.a0   = a0;
        e.data = w ? d : status;
        exp_q.push_back(e);
        if (!w) n_rd_exp++;
        @(posedge clk);
        #1;
        // Scramble the command inputs so un-latched use shows up on the pins.
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'($urandom);
        bus.cmd_a0    = 1'($urandom);
        bus.cmd_write = 1'($urandom);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (bus.cmd_ready) break;
        end
        chk("cmd_ready_latency", lat, S + P + H + 1);
    endtask

    task automatic do_int(input logic [7:0] vec, input bit drop_enable);
        bit ok;
        exp_t e;
        pic_vector = vec;
        e.kind = K_INTA; e.a0 = 1'b0; e.data = vec;
        exp_q.push_back(e);
        n_inta_exp++;
        @(negedge clk);
        bus.int_enable = 1'b1;
        bus.interrupt  = 1'b1;
        wait_inta_low(ok);
        chk("inta_start_timeout", ok, 1);
        if (drop_enable) bus.int_enable = 1'b0;
        else             bus.interrupt  = 1'b0;
        wait_vv(ok);
        chk("vector_valid_timeout", ok, 1);
        bus.interrupt = 1'b0;
        repeat (3) @(negedge clk);
        bus.int_enable = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   waited;
        bit   ok;
        int   cnt;
        int   r;
        exp_t e;

        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_a0     = 1'b0;
        bus.cmd_data   = 8'h00;
        bus.int_enable = 1'b0;
        bus.interrupt  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cs_n",     bus.chip_select_n, 1);
        chk("rst_read_n",   bus.read_n, 1);
        chk("rst_write_n",  bus.write_n, 1);
        chk("rst_inta_n",   bus.interrupt_acknowledge_n, 1);
        chk("rst_a0",       bus.ao_address_line, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_data_oe",  bus.data_out_enable, 0);
        chk("rst_rsp_v",    bus.rsp_valid, 0);
        chk("rst_rsp_d",    bus.rsp_data, 0);
        chk("rst_vec_v",    bus.vector_valid, 0);
        chk("rst_vec",      bus.vector, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        #2 rst_n = 1'b1;
        bus.int_enable = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // Initialisation sequence then a status read.
        do_cmd(1'b1, 1'b0, 8'h13, 8'h00, waited);
        do_cmd(1'b1, 1'b1, 8'hA8, 8'h00, waited);
        do_cmd(1'b1, 1'b1, 8'h03, 8'h00, waited);
        do_cmd(1'b0, 1'b0, 8'h00, 8'h02, waited);

        // Plain interrupt.
        do_int(8'hA9, 1'b0);

        // Collision: interrupt synchronised just as a command is presented.
        pic_vector = 8'h3C;
        e.kind = K_INTA; e.a0 = 1'b0; e.data = 8'h3C;
        exp_q.push_back(e);
        n_inta_exp++;
        @(negedge clk);
        bus.interrupt = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        fork
            do_cmd(1'b1, 1'b1, 8'h77, 8'h00, waited);
            begin
                wait_inta_low(ok);
                chk("collision_inta_timeout", ok, 1);
                bus.interrupt = 1'b0;
            end
        join
        chk("collision_cmd_deferred", waited >= 2 * P + G + 1, 1);
        repeat (3) @(negedge clk);

        // Masked interrupt, then enable and drop INT once INTA1 has begun.
        bus.int_enable = 1'b0;
        bus.interrupt  = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.interrupt_acknowledge_n) cnt++;
        end
        chk("masked_no_inta", cnt, 0);
        pic_vector = 8'h5B;
        e.kind = K_INTA; e.a0 = 1'b0; e.data = 8'h5B;
        exp_q.push_back(e);
        n_inta_exp++;
        bus.int_enable = 1'b1;
        wait_inta_low(ok);
        chk("unmask_inta_timeout", ok, 1);
        bus.interrupt = 1'b0;
        wait_vv(ok);
        chk("unmask_vv_timeout", ok, 1);
        repeat (3) @(negedge clk);

        // Random mix.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      do_cmd(1'b1, 1'($urandom), 8'($urandom), 8'h00, waited);
            else if (r < 7) do_cmd(1'b0, 1'($urandom), 8'h00, 8'($urandom), waited);
            else            do_int(8'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a write strobe.
        @(negedge clk);
        bus.cmd_write = 1'b1;
        bus.cmd_a0    = 1'b1;
        bus.cmd_data  = 8'h5A;
        bus.cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_test_accept", ok, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.write_n) begin ok = 1; break; end
        end
        chk("rst_test_strobe_seen", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_write_n",   bus.write_n, 1);
        chk("midrst_cs_n",      bus.chip_select_n, 1);
        chk("midrst_data_oe",   bus.data_out_enable, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        do_cmd(1'b1, 1'b0, 8'h13, 8'h00, waited);
        do_cmd(1'b0, 1'b1, 8'h00, 8'hC4, waited);

        repeat (10) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("rsp_pulse_count", n_rsp_seen, n_rd_exp);
        chk("vector_pulse_count", n_vv_seen, n_inta_exp);
        chk("monitor_inta_idle", ia_phase, 0);
        chk("monitor_cs_idle", in_cs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached limit 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pic_host_bus_sequencer.md
Name: pic_host_bus_sequencer

Overview:
CPU-side initiator for the 8259A-compatible PIC. It converts single-word host command requests into correctly timed CS/RD/WR/A0 bus cycles, and runs the two-pulse INTA handshake when the PIC raises INTERRUPT. On the second INTA pulse it captures the interrupt vector and presents it to the host core. It sits between the CPU core model and the PIC data/control pins.

Parameters:
SETUP_CYCLES, 1, cycles CS/A0/data are stable before the RD/WR strobe asserts (1..15)
PULSE_CYCLES, 2, strobe and INTA pulse width in cycles (1..15)
HOLD_CYCLES, 1, cycles CS/A0/data are held after the strobe deasserts (1..15)
INTA_GAP_CYCLES, 2, high time between the two INTA pulses (1..15)

Ports:
CLOCK  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  host command request
CMD_READY  out  1  sequencer accepts a command this cycle
CMD_WRITE  in  1  1=write command word, 0=read status
CMD_A0  in  1  A0 value for the cycle
CMD_DATA  in  8  word to write (ICW/OCW)
RSP_VALID  out  1  one-cycle pulse, read data available
RSP_DATA  out  8  captured read data
INT_ENABLE  in  1  host interrupt enable (IF)
VECTOR_VALID  out  1  one-cycle pulse, vector captured
VECTOR  out  8  captured vector
CHIP_SELECT_N  out  1  PIC chip select, active low
READ_N  out  1  read strobe, active low
WRITE_N  out  1  write strobe, active low
AO_ADDRESS_LINE  out  1  PIC A0
DATA_OUT  out  8  write data toward PIC
DATA_OUT_ENABLE  out  1  drive enable for the external tri-state buffer
DATA_IN  in  8  data bus from PIC
INTERRUPT  in  1  PIC INT, asynchronous
INTERRUPT_ACKNOWLEDGE_N  out  1  INTA, active low

Behaviour:
- Reset (async, RESET_N=0): state IDLE; CHIP_SELECT_N, READ_N, WRITE_N, INTERRUPT_ACKNOWLEDGE_N = 1; AO_ADDRESS_LINE, DATA_OUT, DATA_OUT_ENABLE, RSP_*, VECTOR* = 0; CMD_READY = 0 while RESET_N=0.
- INTERRUPT passes through a 2-flop synchronizer; int_req = synced INTERRUPT & INT_ENABLE.
- CMD_READY = 1 only in IDLE when int_req=0. A handshake occurs on CMD_VALID & CMD_READY; CMD_* is latched on that edge.
- FSM states: IDLE, SETUP, STROBE, HOLD, INTA1, INTA_GAP, INTA2, INTA_END.
- IDLE: if int_req -> INTA1 (interrupt has priority over a simultaneous CMD_VALID, which is not accepted). Else on handshake -> SETUP.
- SETUP (SETUP_CYCLES): CHIP_SELECT_N=0; A0 driven. For a write, DATA_OUT_ENABLE=1. -> STROBE.
- STROBE (PULSE_CYCLES): WRITE_N=0 for a write, READ_N=0 for a read. On a read, DATA_IN is sampled in the last STROBE cycle. -> HOLD.
- HOLD (HOLD_CYCLES): strobes=1; CS/A0/data held. On exit: CS_N=1, DATA_OUT_ENABLE=0. A read pulses RSP_VALID for 1 cycle with RSP_DATA. -> IDLE.
- INTA1 (PULSE_CYCLES): INTA_N=0, CS_N=1, DATA_OUT_ENABLE=0. -> INTA_GAP (INTA_GAP_CYCLES, INTA_N=1) -> INTA2.
- INTA2 (PULSE_CYCLES): INTA_N=0. DATA_IN is sampled into VECTOR in the last cycle. -> INTA_END.
- INTA_END (1 cycle): INTA_N=1, VECTOR_VALID=1. -> IDLE.
- Once INTA1 is entered, the INTA sequence always completes, even if INTERRUPT drops or INT_ENABLE clears. VECTOR holds the bus value (spurious-vector handling belongs to the host).
- A bus cycle in progress is never aborted by int_req; the INTA sequence starts from IDLE afterwards.
- One shared 4-bit down-counter times every timed state: loaded with param-1 on state entry, advances at 0.
- Write command latency, handshake to CMD_READY re-high: SETUP+PULSE+HOLD+1 cycles (default 5).
- Async reset mid-cycle: all strobes deassert immediately; no RSP/VECTOR pulse is produced.
- Only one of READ_N, WRITE_N, INTA_N is low at any time. CS_N is never low during INTA. Both are required invariants.

Decomposition:
- Shared package pic_bus_pkg: FSM state enum, timing parameter defaults, ICW/OCW bit-field constants (ICW1_INIT=bit4, OCW3_SEL=bit3) for reuse by benches and the PIC.
- Sub-module pic_sync2 (2-flop synchronizer) is instantiated for INTERRUPT. Everything else stays flat.

Test Plan:
- Write ICW1: CMD_WRITE=1, A0=0, DATA=0x13 -> CS_N low 4 cycles, WRITE_N low exactly cycles 2-3 after SETUP, DATA_OUT=0x13 with DATA_OUT_ENABLE=1 throughout; CMD_READY high again 5 cycles after the handshake.
- Full init plus status read: ICW1 0x13, ICW2 0xA8 (A0=1), ICW4 0x03 (A0=1), then a read with A0=0 while DATA_IN=0x02 -> RSP_VALID single pulse, RSP_DATA=0x02, READ_N never low during the writes.
- Interrupt: INT_ENABLE=1, INTERRUPT raised with DATA_IN=0xA9 during the second pulse -> two INTA_N pulses of 2 cycles separated by 2 high cycles, VECTOR_VALID pulse, VECTOR=0xA9, CS_N=1 throughout.
- Collision: INTERRUPT synced in the same cycle as CMD_VALID -> command not accepted, INTA sequence runs first, then the command completes.
- Masking and late drop: INT_ENABLE=0 with INTERRUPT=1 -> no INTA. Enable then drop INTERRUPT after INTA1 starts -> the sequence still completes with one VECTOR_VALID.
- Reset during STROBE of a write -> WRITE_N/CS_N=1 in the same time step, DATA_OUT_ENABLE=0, no RSP_VALID; normal operation resumes after release.
